// File: rtl/game_status_tracker.sv
// Brick-breaker level status tracker: remaining brick health, player lives and a
// four-state level FSM (IDLE / PLAYING / WON / LOST) with a one-cycle win pulse.
module game_status_tracker #(
  parameter int HEALTH_W    = 10,
  parameter int LIVES_W     = 3,
  parameter int START_LIVES = 3,
  parameter int DMG_W       = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                level_load,
  input  logic [HEALTH_W-1:0] total_health,
  input  logic                game_write,
  input  logic                brick_hit,
  input  logic [DMG_W-1:0]    hit_damage,
  input  logic                ball_lost,
  output logic [HEALTH_W-1:0] health_remaining,
  output logic [LIVES_W-1:0]  lives_remaining,
  output logic                playing,
  output logic                win_occurred,
  output logic                lose_occurred,
  output logic                win_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_WON     = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  localparam logic [LIVES_W-1:0] START_LIVES_V = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] ONE_LIFE      = LIVES_W'(1);

  state_t                state_reg, state_next;
  logic [HEALTH_W-1:0]   health_reg, health_next;
  logic [LIVES_W-1:0]    lives_reg, lives_next;
  logic                  win_pulse_reg, win_pulse_next;

  // Damage widened to the health width so the saturating subtract compares like with like.
  logic [HEALTH_W-1:0]   damage_ext;
  logic [HEALTH_W-1:0]   hit_health;

  assign damage_ext = HEALTH_W'(hit_damage);

  // Health after applying the current hit, clamped at zero instead of wrapping.
  always_comb begin
    hit_health = health_reg;
    if (brick_hit) begin
      if (health_reg > damage_ext)
        hit_health = health_reg - damage_ext;
      else
        hit_health = '0;
    end
  end

  // State and counter registers; reset forces a fresh game in IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      health_reg    <= '0;
      lives_reg     <= START_LIVES_V;
      win_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      health_reg    <= health_next;
      lives_reg     <= lives_next;
      win_pulse_reg <= win_pulse_next;
    end
  end

  // Next-state logic: level_load beats game events; a winning hit beats a lost ball.
  always_comb begin
    state_next     = state_reg;
    health_next    = health_reg;
    lives_next     = lives_reg;
    win_pulse_next = 1'b0;
    if (level_load) begin
      health_next = total_health;
      // A load from IDLE or LOST starts a new game; from PLAYING or WON lives carry over.
      if (state_reg == ST_IDLE || state_reg == ST_LOST)
        lives_next = START_LIVES_V;
      if (total_health == '0) begin
        state_next     = ST_WON;
        win_pulse_next = 1'b1;
      end else begin
        state_next = ST_PLAYING;
      end
    end else if (state_reg == ST_PLAYING && game_write) begin
      health_next = hit_health;
      if (brick_hit && hit_health == '0) begin
        // Level cleared: the simultaneous lost ball (if any) is forgiven.
        state_next     = ST_WON;
        win_pulse_next = 1'b1;
      end else if (ball_lost) begin
        lives_next = lives_reg - ONE_LIFE;
        if (lives_reg == ONE_LIFE)
          state_next = ST_LOST;
      end
    end
  end

  // Output decode straight from registered state and counters.
  always_comb begin
    health_remaining = health_reg;
    lives_remaining  = lives_reg;
    playing          = (state_reg == ST_PLAYING);
    win_occurred     = (state_reg == ST_WON);
    lose_occurred    = (state_reg == ST_LOST);
    win_pulse        = win_pulse_reg;
  end

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed bench for game_status_tracker with hand-computed expectations.
module tb_game_status_tracker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       level_load;
  logic [9:0] total_health;
  logic       game_write;
  logic       brick_hit;
  logic [1:0] hit_damage;
  logic       ball_lost;
  logic [9:0] health_remaining;
  logic [2:0] lives_remaining;
  logic       playing;
  logic       win_occurred;
  logic       lose_occurred;
  logic       win_pulse;

  int checks = 0;
  int failures = 0;

  game_status_tracker #(
    .HEALTH_W(10), .LIVES_W(3), .START_LIVES(3), .DMG_W(2)
  ) dut (
    .clk(clk), .resetn(resetn), .level_load(level_load), .total_health(total_health),
    .game_write(game_write), .brick_hit(brick_hit), .hit_damage(hit_damage),
    .ball_lost(ball_lost), .health_remaining(health_remaining),
    .lives_remaining(lives_remaining), .playing(playing), .win_occurred(win_occurred),
    .lose_occurred(lose_occurred), .win_pulse(win_pulse)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic ld, input logic [9:0] th, input logic gw,
                      input logic bh, input logic [1:0] dmg, input logic bl);
    level_load   = ld;
    total_health = th;
    game_write   = gw;
    brick_hit    = bh;
    hit_damage   = dmg;
    ball_lost    = bl;
    @(posedge clk);
    #1;
    level_load = 1'b0;
    game_write = 1'b0;
    brick_hit  = 1'b0;
    ball_lost  = 1'b0;
    hit_damage = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full status check, one line per transaction.
  task automatic status(input string tag, input int h, input int l, input logic p,
                        input logic w, input logic lo, input logic wp);
    chk({tag, ".health"}, 32'(health_remaining), 32'(h));
    chk({tag, ".lives"}, 32'(lives_remaining), 32'(l));
    chk({tag, ".playing"}, 32'(playing), 32'(p));
    chk({tag, ".win"}, 32'(win_occurred), 32'(w));
    chk({tag, ".lose"}, 32'(lose_occurred), 32'(lo));
    chk({tag, ".win_pulse"}, 32'(win_pulse), 32'(wp));
    $display("%s: health=%0d lives=%0d playing=%0b win=%0b lose=%0b win_pulse=%0b",
             tag, health_remaining, lives_remaining, playing, win_occurred,
             lose_occurred, win_pulse);
  endtask

  initial begin
    resetn = 1'b0;
    level_load = 1'b0; total_health = '0; game_write = 1'b0;
    brick_hit = 1'b0; hit_damage = '0; ball_lost = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    status("reset", 0, 3, 0, 0, 0, 0);
    resetn = 1'b1;

    // Events in IDLE are ignored.
    step(0, 0, 1, 1, 2'd1, 1);
    status("idle_ignore", 0, 3, 0, 0, 0, 0);

    // Test 1: load 5, five single-damage hits.
    step(1, 10'd5, 0, 0, 0, 0);
    status("t1_load", 5, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0); status("t1_hit1", 4, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0); status("t1_hit2", 3, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0); status("t1_hit3", 2, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0); status("t1_hit4", 1, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0); status("t1_hit5", 0, 3, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);    status("t1_hold", 0, 3, 0, 1, 0, 0);

    // Test 2: saturation, then a hit in WON is ignored.
    step(1, 10'd3, 0, 0, 0, 0); status("t2_load", 3, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd3, 0);  status("t2_hit3", 0, 3, 0, 1, 0, 1);
    step(0, 0, 1, 1, 2'd2, 0);  status("t2_hit_won", 0, 3, 0, 1, 0, 0);

    // Saturation with damage larger than remaining health.
    step(1, 10'd2, 0, 0, 0, 0); status("t2b_load", 2, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd3, 0);  status("t2b_sat", 0, 3, 0, 1, 0, 1);

    // Test 3: lives run out.
    step(1, 10'd10, 0, 0, 0, 0); status("t3_load", 10, 3, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);      status("t3_lost1", 10, 2, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);      status("t3_lost2", 10, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);      status("t3_lost3", 10, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1);      status("t3_lost4", 10, 0, 0, 0, 1, 0);

    // Test 4: load from LOST restores lives; winning hit forgives the lost ball.
    step(1, 10'd2, 0, 0, 0, 0); status("t4_load", 2, 3, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);     status("t4_lost1", 2, 2, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);     status("t4_lost2", 2, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd2, 1);  status("t4_both", 0, 1, 0, 1, 0, 1);

    // Test 5: game_write gating, load priority, zero damage, non-winning hit+lost.
    step(1, 10'd7, 0, 0, 0, 0); status("t5_load", 7, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 2'd3, 1);  status("t5_nowrite", 7, 1, 1, 0, 0, 0);
    step(1, 10'd9, 1, 1, 2'd3, 0); status("t5_load_hit", 9, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd0, 0);  status("t5_dmg0", 9, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd2, 0);  status("t5_dmg2", 7, 1, 1, 0, 0, 0);

    // Test 6: load 0 wins at once; load from WON keeps lives; mid-level reset.
    step(1, 10'd0, 0, 0, 0, 0); status("t6_load0", 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);     status("t6_hold", 0, 1, 0, 1, 0, 0);
    step(1, 10'd8, 0, 0, 0, 0); status("t6_load8", 8, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 0);  status("t6_hit", 7, 1, 1, 0, 0, 0);
    resetn = 1'b0;
    step(1, 10'd4, 1, 1, 2'd1, 1); status("t6_reset", 0, 3, 0, 0, 0, 0);
    resetn = 1'b1;

    // Lose then continue play: a ball lost with a non-winning hit applies both.
    step(1, 10'd6, 0, 0, 0, 0); status("t7_load", 6, 3, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2'd1, 1);  status("t7_both", 5, 2, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
